// File: rtl/alu_mult_sequencer.sv
// Multi-cycle unsigned shift-add multiplier that drives an external shared ALU in ADD mode.
// It produces the low WIDTH product bits plus a flag for any nonzero high-half bit.
module alu_mult_sequencer #(
    parameter int unsigned WIDTH      = 64,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             hi_nz,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [2:0]       alu_cntrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             hi_nz_q, hi_nz_d;

    logic accept;
    logic rest_zero;
    logic last_iter;
    logic hi_set;

    assign accept    = (state_q != StRun) && start;
    assign rest_zero = (mplier_q[WIDTH-1:1] == '0);
    assign last_iter = (count_q == LAST_COUNT) || (EARLY_EXIT && rest_zero);
    // Overflow shows up either as an adder carry or as a multiplicand bit about to be
    // shifted out while higher multiplier bits remain to be consumed.
    assign hi_set    = (mplier_q[0] & alu_carry_out) | (mcand_q[WIDTH-1] & ~rest_zero);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;
        hi_nz_d   = hi_nz_q;

        unique case (state_q)
            StIdle: state_d = StIdle;
            StRun: begin
                acc_d    = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (hi_set) begin
                    hi_nz_d = 1'b1;
                end
                if (last_iter) begin
                    product_d = alu_result;
                    state_d   = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            mcand_d  = a_in;
            mplier_d = b_in;
            acc_d    = '0;
            count_d  = '0;
            hi_nz_d  = 1'b0;
            state_d  = StRun;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            hi_nz_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
            hi_nz_q   <= hi_nz_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign product   = product_q;
    assign hi_nz     = hi_nz_q;
    assign alu_A     = acc_q;
    assign alu_B     = mplier_q[0] ? mcand_q : '0;
    assign alu_cntrl = busy ? 3'b010 : 3'b000;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer: an early-exit instance and a fixed-length instance,
// each paired with a behavioural 64-bit adder standing in for the shared ALU.
module tb_alu_mult_sequencer;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, start_f;
    logic [W-1:0] a_in, b_in, a_f, b_f;

    logic         busy, done, hi_nz;
    logic [W-1:0] product, alu_A, alu_B, alu_result;
    logic [2:0]   alu_cntrl;
    logic         alu_carry_out;

    logic         busy_f, done_f, hi_nz_f;
    logic [W-1:0] product_f, alu_A_f, alu_B_f, alu_result_f;
    logic [2:0]   alu_cntrl_f;
    logic         alu_carry_out_f;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign {alu_carry_out, alu_result}     = {1'b0, alu_A} + {1'b0, alu_B};
    assign {alu_carry_out_f, alu_result_f} = {1'b0, alu_A_f} + {1'b0, alu_B_f};

    alu_mult_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .product(product), .hi_nz(hi_nz),
        .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out)
    );

    alu_mult_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .reset(reset), .start(start_f), .a_in(a_f), .b_in(b_f),
        .busy(busy_f), .done(done_f), .product(product_f), .hi_nz(hi_nz_f),
        .alu_A(alu_A_f), .alu_B(alu_B_f), .alu_cntrl(alu_cntrl_f),
        .alu_result(alu_result_f), .alu_carry_out(alu_carry_out_f)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Counts cycles from the accepting edge until done; done should sit in cycle K+1.
    task automatic run_op(input bit full, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_p, input logic exp_h, input int exp_k,
                          input string name);
        int cycles;
        @(negedge clk);
        if (full) begin
            start_f = 1'b1; a_f = a; b_f = b;
        end else begin
            start = 1'b1; a_in = a; b_in = b;
        end
        @(negedge clk);
        start = 1'b0; start_f = 1'b0;
        cycles = 1;
        check({name, " busy"}, W'(full ? busy_f : busy), W'(1));
        check({name, " cntrl"}, W'(full ? alu_cntrl_f : alu_cntrl), W'(3'b010));
        while (!(full ? done_f : done) && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        check({name, " done cycle"}, W'(cycles), W'(exp_k + 1));
        check({name, " product"}, full ? product_f : product, exp_p);
        check({name, " hi_nz"}, W'(full ? hi_nz_f : hi_nz), W'(exp_h));
        @(negedge clk);
        check({name, " done pulse width"}, W'(full ? done_f : done), W'(0));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] p;
        logic         h;
        int           k;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int  cycles;
        bit  saw_done;

        vecs[0] = '{64'd3, 64'd5, 64'd15, 1'b0, 3};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 2};
        vecs[2] = '{64'h1234, 64'd0, 64'd0, 1'b0, 1};
        vecs[3] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1, 33};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'd3, 64'h8000_0000_0000_0000, 1'b1, 2};
        vecs[5] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 32};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64};
        vecs[7] = '{64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64};

        reset = 1'b1; start = 1'b0; start_f = 1'b0;
        a_in = '0; b_in = '0; a_f = '0; b_f = '0;
        #1;
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset product", product, W'(0));
        check("reset hi_nz", W'(hi_nz), W'(0));
        check("reset cntrl", W'(alu_cntrl), W'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].h, vecs[i].k,
                   $sformatf("vec%0d", i));
        end

        run_op(1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b1, 64, "full 2^32*2^32");
        run_op(1'b1, 64'd3, 64'd5, 64'd15, 1'b0, 64, "full 3*5");

        // Start while busy must be ignored, along with operand changes after acceptance.
        @(negedge clk);
        start = 1'b1; a_in = 64'd7; b_in = 64'd9;
        @(negedge clk);
        a_in = 64'd1; b_in = 64'd1;
        @(negedge clk);
        start = 1'b0;
        cycles = 2;
        check("busy start busy", W'(busy), W'(1));
        while (!done && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        check("busy start done cycle", W'(cycles), W'(5));
        check("busy start product", product, 64'd63);
        @(negedge clk);
        check("busy start no rerun", W'(busy), W'(0));

        // Start presented in the DONE cycle is taken back-to-back.
        @(negedge clk);
        start = 1'b1; a_in = 64'd3; b_in = 64'd5;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        check("b2b first done cycle", W'(cycles), W'(4));
        check("b2b first product", product, 64'd15);
        start = 1'b1; a_in = 64'd6; b_in = 64'd7;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        check("b2b second busy", W'(busy), W'(1));
        while (!done && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        check("b2b second done cycle", W'(cycles), W'(4));
        check("b2b second product", product, 64'd42);

        // Reset mid-run aborts without a done pulse and clears the held product.
        @(negedge clk);
        start = 1'b1; a_in = '1; b_in = '1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", W'(busy), W'(0));
        check("abort done", W'(done), W'(0));
        check("abort product", product, W'(0));
        check("abort hi_nz", W'(hi_nz), W'(0));
        check("abort cntrl", W'(alu_cntrl), W'(0));
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort stays idle", W'(saw_done), W'(0));
        run_op(1'b0, 64'd6, 64'd7, 64'd42, 1'b0, 3, "after abort 6*7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
